// File: rtl/seg_pkg.sv
// Shared constants, state encoding and leading-zero helper for the display scanner.
package seg_pkg;

  // Upper bound on digit count handled by the leading-zero helper.
  localparam int unsigned MAX_DIGITS = 16;

  // Active-low segments: all ones means every segment dark.
  localparam logic [0:6] SEG_OFF = 7'b1111111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_BLANK = ST_BLANK,
    S_SHOW  = ST_SHOW
  } state_e;

  // Bit i set when digit i is a leading zero to be blanked; digit 0 is never blanked.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] nibbles,
                                                    input int unsigned digits,
                                                    input logic en);
    logic [MAX_DIGITS-1:0] mask;
    logic leading;
    mask    = '0;
    leading = 1'b1;
    for (int unsigned i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < digits) begin
        leading = leading & (nibbles[4*i +: 4] == 4'd0);
        mask[i] = en & leading;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/decoder_0_F.sv
// Hex nibble to active-low seven-segment pattern, segments ordered a..g as [0:6].
module decoder_0_F
  import seg_pkg::*;
(
  input  logic [3:0] bin,
  output logic [0:6] seg
);

  // Combinational lookup of the 0-F glyph set.
  always_comb begin
    seg = SEG_OFF;
    unique case (bin)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: one shared decoder, per-slot blanking dead-time,
// frame-level snapshot of the displayed value and optional leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned S         = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  lz_supp,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [0:S-1]          seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_start
);

  localparam int unsigned PERIOD = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam int unsigned IDX_W  = $clog2(DIGITS);

  localparam logic [CNT_W-1:0]  CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST       = CNT_W'(PERIOD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST       = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE         = DIGITS'(1);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [4*DIGITS-1:0]   snap_dig_q;
  logic [DIGITS-1:0]     snap_dp_q;
  logic                  snap_lz_q;

  logic [3:0]               cur_nib;
  logic [0:6]               dec_seg;
  logic [4*MAX_DIGITS-1:0]  nib_pad;
  logic [MAX_DIGITS-1:0]    lz_full;
  logic [DIGITS-1:0]        blank_vec;

  // Select the current digit's snapshot nibble and its leading-zero blanking flag.
  always_comb begin
    nib_pad                 = '0;
    nib_pad[4*DIGITS-1:0]   = snap_dig_q;
    lz_full                 = lz_mask(nib_pad, DIGITS, snap_lz_q);
    blank_vec               = lz_full[DIGITS-1:0];
    cur_nib                 = snap_dig_q[{idx_q, 2'b00} +: 4];
  end

  decoder_0_F u_dec (
    .bin (cur_nib),
    .seg (dec_seg)
  );

  // Scan FSM with slot counter, digit index, frame snapshot and registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      snap_dig_q  <= '0;
      snap_dp_q   <= '0;
      snap_lz_q   <= 1'b0;
      an_out      <= '1;
      seg_out     <= SEG_OFF;
      dp_out      <= 1'b1;
      frame_start <= 1'b0;
    end else if (!enable) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      an_out      <= '1;
      seg_out     <= SEG_OFF;
      dp_out      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          state_q     <= S_BLANK;
          cnt_q       <= '0;
          idx_q       <= '0;
          snap_dig_q  <= digits_in;
          snap_dp_q   <= dp_in;
          snap_lz_q   <= lz_supp;
          frame_start <= 1'b1;
        end
        S_BLANK: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_BLANK_LAST) begin
            state_q <= S_SHOW;
            an_out  <= ~(AN_ONE << idx_q);
            seg_out <= blank_vec[idx_q] ? SEG_OFF : dec_seg;
            dp_out  <= ~snap_dp_q[idx_q];
          end
        end
        S_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_BLANK;
            an_out  <= '1;
            seg_out <= SEG_OFF;
            dp_out  <= 1'b1;
            if (idx_q == IDX_LAST) begin
              // Wrapping to digit 0 starts a new frame: take a fresh snapshot.
              idx_q       <= '0;
              snap_dig_q  <= digits_in;
              snap_dp_q   <= dp_in;
              snap_lz_q   <= lz_supp;
              frame_start <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed display scanner that shares one `decoder_0_F` instance among `DIGITS` seven-segment digits. It sits between the counter or `bcd_decoder`-style value logic and the board pins. It cycles the common-anode enables, feeds each digit's BCD nibble through the shared decoder, and inserts a blanking dead-time between digits to suppress ghosting. Frames are snapshotted so a display never mixes old and new digit values.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency.
- `SCAN_HZ`, 1000, per-digit slot rate; `PERIOD = CLK_HZ/SCAN_HZ` cycles per slot, must be ≥ 2.
- `DIGITS`, 4, number of multiplexed digits, must be ≥ 2.
- `BLANK_CYC`, 500, dead-time cycles at the start of each slot, must satisfy 1 ≤ `BLANK_CYC` < `PERIOD`.
- `S`, 7, segment count.

Ports:
- `clk`  in  1  single system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  scanning on when high; display dark when low.
- `lz_supp`  in  1  leading-zero suppression enable.
- `digits_in`  in  4*DIGITS  BCD nibbles; nibble i is `[4i+3:4i]`, and digit 0 is the least significant.
- `dp_in`  in  DIGITS  decimal-point request per digit.
- `seg_out`  out  [0:S-1]  active-low segments, taken from the `decoder_0_F` pattern.
- `dp_out`  out  1  active-low decimal point.
- `an_out`  out  DIGITS  active-low digit enables; at most one bit is low.
- `frame_start`  out  1  one-cycle pulse at each frame snapshot.

## Operation
- States are `IDLE`, `BLANK`, and `SHOW`. A slot counter `cnt` runs 0..PERIOD-1, and a digit index `idx` runs 0..DIGITS-1.
- In `IDLE`, all outputs are off and `cnt` = `idx` = 0.
- `IDLE` to `BLANK`: when `enable` is sampled high, with `idx` = 0 and `cnt` = 0.
- `BLANK` to `SHOW`: when `cnt` = BLANK_CYC-1.
- `SHOW` to `BLANK`: when `cnt` = PERIOD-1. `cnt` resets to 0 and `idx` increments, wrapping from DIGITS-1 to 0.
- Any state goes to `IDLE` on the first edge where `enable` is sampled low. Re-enable always restarts at digit 0.
- Snapshot: `digits_in`, `dp_in`, and `lz_supp` are captured into internal registers on every entry to `BLANK` with `idx` = 0. That same cycle asserts `frame_start`. Mid-frame input changes take effect only at the next frame.
- In `BLANK`: `an_out` is all ones, `seg_out` is all ones, and `dp_out` = 1.
- In `SHOW`: bit `idx` of `an_out` is 0 and all other bits are 1. `seg_out` = `decoder_0_F`(snapshot nibble `idx`), and `dp_out` = ~snapshot `dp_in[idx]`.
- Leading-zero suppression: digit i (i ≥ 1) is blanked when `lz_supp` is set and snapshot nibbles DIGITS-1..i are all zero. A blanked digit shows `seg_out` all ones, while its `an_out` bit is still driven low and `dp_out` is still honoured. Digit 0 is never suppressed.
- Nibbles above 9 pass through unchanged, so the decoder shows hex A–F. No saturation is applied.

## Timing
- Reset values (immediate and asynchronous): state `IDLE`, `an_out` all ones, `seg_out` all ones, `dp_out` 1, `frame_start` 0, snapshot registers 0.
- All outputs are registered. They reflect the state and counter of the current cycle one clock later, so `enable` high to the first `frame_start` is 1 cycle.
- The first anode asserts BLANK_CYC cycles after `frame_start`.
- Each digit is lit for exactly PERIOD-BLANK_CYC cycles. A full frame is DIGITS×PERIOD cycles.
- `frame_start` has a period of DIGITS×PERIOD cycles while enabled.
- `enable` low results in dark outputs one cycle later.
- Reset asserted mid-`SHOW` forces dark outputs immediately. There are no glitches on `an_out`, because each output is a single flop.
- `cnt` width is $clog2(PERIOD), and `idx` width is $clog2(DIGITS).

## Structure
- Shared package `seg_pkg` holds:
  - the `SEG_OFF` all-ones constant;
  - the state encoding localparams `ST_IDLE`, `ST_BLANK`, `ST_SHOW`;
  - the function that computes leading-zero suppression for a nibble vector.
- Exactly one sub-module is instantiated: the existing `decoder_0_F`, fed from a DIGITS:1 nibble mux.
- The prescaler, FSM, and snapshot registers are inline.

## Test plan
Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (PERIOD=10), BLANK_CYC=2, DIGITS=4.
- Reset, then hold `enable`=0 for 50 cycles: `an_out`=4'b1111, `seg_out`=7'b1111111, `dp_out`=1, and no `frame_start` pulses.
- Set `enable`=1 with `digits_in`=16'h1234: `frame_start` pulses every 40 cycles. Digits 0..3 show in order with an `an_out` sequence of 1110, 1101, 1011, 0111, each low for 8 cycles after 2 dark cycles. The segment patterns are `decoder_0_F`(4,3,2,1).
- Set `lz_supp`=1 with `digits_in`=16'h0050: digits 3 and 2 are segment-blank, and digits 1 and 0 show 5 and 0. With `digits_in`=16'h0000, only digit 0 shows 0.
- Change `digits_in` from 16'h1234 to 16'h9999 while digit 1 is lit: the rest of the current frame still shows 3, 2, 1, and the next frame shows 9, 9, 9, 9.
- Drop `enable` mid-`SHOW` of digit 2, then raise it again after 5 cycles: outputs are dark one cycle after the drop, and scanning restarts at digit 0 with a fresh `frame_start`.
- Assert `rst` mid-frame: outputs are dark in the same cycle, with no anode low. After release with `enable`=1, scanning restarts at digit 0. With `dp_in`=4'b0100, `dp_out`=0 only during digit 2's `SHOW` window.
